wb_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave Wishbone B4 classic arbiter with round-robin fairness and a bus-timeout watchdog. It sits between the CPU fetch/load-store masters (plus DMA or debug masters) and the shared system bus or slave decoder. It generalises the fixed 32-bit single-master WB4 link in width and master count. A stalled slave is aborted with ERR instead of hanging the core.

---
 rtl/wb_rr_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master to 1-slave Wishbone B4 classic arbiter.
// Round-robin ownership with one idle bus cycle between owners, and a
// watchdog that aborts a stalled strobe with ERR instead of hanging.

module wb_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADR_W     = 32,
    parameter int DAT_W     = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MASTERS-1:0]       m_cyc,
    input  logic [N_MASTERS-1:0]       m_stb,
    input  logic [N_MASTERS-1:0]       m_we,
    input  logic [N_MASTERS*ADR_W-1:0] m_adr,
    input  logic [N_MASTERS*DAT_W-1:0] m_dat_o,
    output logic [DAT_W-1:0]           m_dat_i,
    output logic [N_MASTERS-1:0]       m_ack,
    output logic [N_MASTERS-1:0]       m_err,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    output logic [ADR_W-1:0]           s_adr,
    output logic [DAT_W-1:0]           s_dat_o,
    input  logic [DAT_W-1:0]           s_dat_i,
    input  logic                       s_ack,
    input  logic                       s_err,
    output logic [N_MASTERS-1:0]       grant,
    output logic                       timeout_evt
);

    localparam int OWN_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    // A zero-width counter is illegal, so a disabled watchdog keeps one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ABORT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [OWN_W-1:0] owner;
    logic [OWN_W-1:0] owner_nxt;
    logic [OWN_W-1:0] rr_ptr;
    logic [OWN_W-1:0] rr_ptr_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_nxt;

    logic own_cyc;
    logic own_stb;
    logic own_we;

    logic [ADR_W-1:0] adr_arr [N_MASTERS];
    logic [DAT_W-1:0] dat_arr [N_MASTERS];

    // First requester at or above ptr, wrapping at N_MASTERS.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                  input logic [OWN_W-1:0]     ptr);
        logic [OWN_W-1:0] pick;
        logic [OWN_W-1:0] sel;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            sel = OWN_W'(idx);
            if (!found && req[sel]) begin
                pick  = sel;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Index of the master after idx, wrapping to 0.
    function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] idx);
        if (idx == OWN_W'(N_MASTERS - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Saturating increment so the stall counter can never wrap to 0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_W'(TIMEOUT)) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign adr_arr[gi] = m_adr[gi*ADR_W +: ADR_W];
            assign dat_arr[gi] = m_dat_o[gi*DAT_W +: DAT_W];
        end
    endgenerate

    assign own_cyc = m_cyc[owner];
    assign own_stb = m_stb[owner];
    assign own_we  = m_we[owner];

    // Read data is broadcast; only the ack/err qualifies it for a master.
    assign m_dat_i = s_dat_i;

    // State, owner, round-robin pointer and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            wd_cnt <= wd_cnt_nxt;
        end
    end

    // Next-state logic: arbitration, release detection and watchdog abort.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        wd_cnt_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (|m_cyc) begin
                    owner_nxt = rr_pick(m_cyc, rr_ptr);
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!own_cyc) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = next_idx(owner);
                end else if (TIMEOUT > 0 && own_stb && !s_ack && !s_err) begin
                    wd_cnt_nxt = sat_inc(wd_cnt);
                    // This edge takes the counter to TIMEOUT.
                    if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_nxt = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = next_idx(owner);
                end else begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!own_cyc) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = next_idx(owner);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output mux: owner drives the slave in GRANT; ABORT returns ERR once.
    always_comb begin
        s_cyc       = 1'b0;
        s_stb       = 1'b0;
        s_we        = 1'b0;
        s_adr       = '0;
        s_dat_o     = '0;
        m_ack       = '0;
        m_err       = '0;
        grant       = '0;
        timeout_evt = 1'b0;
        case (state)
            ST_GRANT: begin
                s_cyc        = own_cyc;
                s_stb        = own_stb;
                s_we         = own_we;
                s_adr        = adr_arr[owner];
                s_dat_o      = dat_arr[owner];
                m_ack[owner] = s_ack;
                m_err[owner] = s_err;
                grant[owner] = 1'b1;
            end
            ST_ABORT: begin
                m_err[owner] = 1'b1;
                timeout_evt  = 1'b1;
                grant[owner] = 1'b1;
            end
            ST_RELEASE: begin
                grant[owner] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed vector bench for wb_rr_arbiter (2 masters,
// watchdog of 4 stalled cycles).

module tb_wb_rr_arbiter;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] D0 = 32'hA0A0_A0A0;
    localparam logic [31:0] D1 = 32'hB1B1_B1B1;

    logic        clk;
    logic        rst;
    logic [1:0]  m_cyc;
    logic [1:0]  m_stb;
    logic [1:0]  m_we;
    logic [63:0] m_adr;
    logic [63:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [31:0] s_adr;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack;
    logic        s_err;
    logic [1:0]  grant;
    logic        timeout_evt;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [1:0]  we;
        logic        ack;
        logic        err;
        logic [31:0] sdat;
        logic [1:0]  e_grant;
        logic        e_scyc;
        logic        e_sstb;
        logic        e_swe;
        logic [31:0] e_adr;
        logic [31:0] e_sdo;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
        logic        e_tevt;
    } vec_t;

    vec_t vq[$];

    wb_rr_arbiter #(
        .N_MASTERS(2),
        .ADR_W(32),
        .DAT_W(32),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_cyc(m_cyc),
        .m_stb(m_stb),
        .m_we(m_we),
        .m_adr(m_adr),
        .m_dat_o(m_dat_o),
        .m_dat_i(m_dat_i),
        .m_ack(m_ack),
        .m_err(m_err),
        .s_cyc(s_cyc),
        .s_stb(s_stb),
        .s_we(s_we),
        .s_adr(s_adr),
        .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),
        .s_ack(s_ack),
        .s_err(s_err),
        .grant(grant),
        .timeout_evt(timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb,
                                input logic [1:0] we, input logic ack, input logic err,
                                input logic [31:0] sdat, input logic [1:0] e_grant,
                                input logic e_scyc, input logic e_sstb, input logic e_swe,
                                input logic [31:0] e_adr, input logic [31:0] e_sdo,
                                input logic [1:0] e_ack, input logic [1:0] e_err,
                                input logic e_tevt);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.err = err; v.sdat = sdat;
        v.e_grant = e_grant; v.e_scyc = e_scyc; v.e_sstb = e_sstb; v.e_swe = e_swe;
        v.e_adr = e_adr; v.e_sdo = e_sdo; v.e_ack = e_ack; v.e_err = e_err;
        v.e_tevt = e_tevt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic [1:0] we,
                         input logic ack, input logic err, input logic [31:0] sdat);
        m_cyc   = cyc;
        m_stb   = stb;
        m_we    = we;
        s_ack   = ack;
        s_err   = err;
        s_dat_i = sdat;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'h0);
        chk({tag, ".s_cyc"}, 32'(s_cyc), 32'h0);
        chk({tag, ".s_stb"}, 32'(s_stb), 32'h0);
        chk({tag, ".s_we"}, 32'(s_we), 32'h0);
        chk({tag, ".s_adr"}, s_adr, 32'h0);
        chk({tag, ".s_dat_o"}, s_dat_o, 32'h0);
        chk({tag, ".m_ack"}, 32'(m_ack), 32'h0);
        chk({tag, ".m_err"}, 32'(m_err), 32'h0);
        chk({tag, ".timeout_evt"}, 32'(timeout_evt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_adr   = {A1, A0};
        m_dat_o = {D1, D0};

        // Round robin from pointer 0: grants 01,10,01,10 with idle gaps.
        vq.push_back(mk(2'b11, 2'b00, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b11, 2'b11, 2'b00, 1, 0, 32'h1111_1111, 2'b01, 1, 1, 0, A0, D0, 2'b01, 2'b00, 0));
        vq.push_back(mk(2'b10, 2'b10, 2'b00, 0, 0, 32'h0, 2'b01, 0, 0, 0, A0, D0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b11, 2'b11, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b11, 2'b11, 2'b00, 1, 0, 32'h2222_2222, 2'b10, 1, 1, 0, A1, D1, 2'b10, 2'b00, 0));
        vq.push_back(mk(2'b01, 2'b01, 2'b00, 0, 0, 32'h0, 2'b10, 0, 0, 0, A1, D1, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b11, 2'b11, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b11, 2'b11, 2'b00, 1, 0, 32'h3333_3333, 2'b01, 1, 1, 0, A0, D0, 2'b01, 2'b00, 0));
        vq.push_back(mk(2'b10, 2'b10, 2'b00, 0, 0, 32'h0, 2'b01, 0, 0, 0, A0, D0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b11, 2'b11, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b11, 2'b11, 2'b00, 1, 0, 32'h4444_4444, 2'b10, 1, 1, 0, A1, D1, 2'b10, 2'b00, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b10, 0, 0, 0, A1, D1, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        // Master 0 read, ack after 2 stalled cycles; ack while dropping CYC still routed.
        vq.push_back(mk(2'b01, 2'b01, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b01, 2'b01, 2'b00, 0, 0, 32'h0, 2'b01, 1, 1, 0, A0, D0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b01, 2'b01, 2'b00, 0, 0, 32'h0, 2'b01, 1, 1, 0, A0, D0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b01, 2'b01, 2'b00, 1, 0, 32'hDEAD_BEEF, 2'b01, 1, 1, 0, A0, D0, 2'b01, 2'b00, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 1, 0, 32'h5555_5555, 2'b01, 0, 0, 0, A0, D0, 2'b01, 2'b00, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        // Master 1 write, ack in the 4th stalled cycle: normal ack, no abort.
        vq.push_back(mk(2'b10, 2'b10, 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b10, 2'b10, 2'b10, 0, 0, 32'h0, 2'b10, 1, 1, 1, A1, D1, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b10, 2'b10, 2'b10, 0, 0, 32'h0, 2'b10, 1, 1, 1, A1, D1, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b10, 2'b10, 2'b10, 0, 0, 32'h0, 2'b10, 1, 1, 1, A1, D1, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b10, 2'b10, 2'b10, 1, 0, 32'hCAFE_F00D, 2'b10, 1, 1, 1, A1, D1, 2'b10, 2'b00, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b10, 0, 0, 0, A1, D1, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        // Master 0 gets a slave error passed straight through.
        vq.push_back(mk(2'b01, 2'b01, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b01, 2'b01, 2'b00, 0, 1, 32'h0, 2'b01, 1, 1, 0, A0, D0, 2'b00, 2'b01, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b01, 0, 0, 0, A0, D0, 2'b00, 2'b00, 0));
        vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0));

        // Reset held with random inputs: outputs 0, read data still follows.
        rst = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), $urandom);
            step();
            #2;
            zero_outputs($sformatf("rst%0d", i));
            chk($sformatf("rst%0d.m_dat_i", i), m_dat_i, s_dat_i);
        end
        step();
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0);
        #3;
        zero_outputs("post_rst");
        step();

        // Table of per-cycle vectors.
        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].cyc, vq[k].stb, vq[k].we, vq[k].ack, vq[k].err, vq[k].sdat);
            #3;
            chk($sformatf("v%0d.grant", k), 32'(grant), 32'(vq[k].e_grant));
            chk($sformatf("v%0d.s_cyc", k), 32'(s_cyc), 32'(vq[k].e_scyc));
            chk($sformatf("v%0d.s_stb", k), 32'(s_stb), 32'(vq[k].e_sstb));
            chk($sformatf("v%0d.s_we", k), 32'(s_we), 32'(vq[k].e_swe));
            chk($sformatf("v%0d.s_adr", k), s_adr, vq[k].e_adr);
            chk($sformatf("v%0d.s_dat_o", k), s_dat_o, vq[k].e_sdo);
            chk($sformatf("v%0d.m_ack", k), 32'(m_ack), 32'(vq[k].e_ack));
            chk($sformatf("v%0d.m_err", k), 32'(m_err), 32'(vq[k].e_err));
            chk($sformatf("v%0d.timeout_evt", k), 32'(timeout_evt), 32'(vq[k].e_tevt));
            chk($sformatf("v%0d.m_dat_i", k), m_dat_i, vq[k].sdat);
            step();
        end

        // Watchdog abort: pointer is 1, both request, slave never answers.
        drive(2'b11, 2'b11, 2'b00, 0, 0, 32'h0);
        #3;
        chk("to_arb.grant", 32'(grant), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("to_stall%0d.grant", i), 32'(grant), 32'h2);
            chk($sformatf("to_stall%0d.s_stb", i), 32'(s_stb), 32'h1);
            chk($sformatf("to_stall%0d.m_err", i), 32'(m_err), 32'h0);
            chk($sformatf("to_stall%0d.timeout_evt", i), 32'(timeout_evt), 32'h0);
            step();
        end
        #3;
        chk("to_abort.s_cyc", 32'(s_cyc), 32'h0);
        chk("to_abort.s_stb", 32'(s_stb), 32'h0);
        chk("to_abort.m_err", 32'(m_err), 32'h2);
        chk("to_abort.timeout_evt", 32'(timeout_evt), 32'h1);
        chk("to_abort.grant", 32'(grant), 32'h2);
        step();
        #3;
        chk("to_rel.s_cyc", 32'(s_cyc), 32'h0);
        chk("to_rel.m_err", 32'(m_err), 32'h0);
        chk("to_rel.timeout_evt", 32'(timeout_evt), 32'h0);
        chk("to_rel.grant", 32'(grant), 32'h2);
        step();
        drive(2'b01, 2'b01, 2'b00, 0, 0, 32'h0);
        #3;
        chk("to_drop.grant", 32'(grant), 32'h2);
        chk("to_drop.s_cyc", 32'(s_cyc), 32'h0);
        step();
        #3;
        chk("to_idle.grant", 32'(grant), 32'h0);
        step();
        #3;
        chk("to_next.grant", 32'(grant), 32'h1);
        chk("to_next.s_cyc", 32'(s_cyc), 32'h1);
        chk("to_next.s_adr", s_adr, A0);
        step();
        drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0);
        step();

        // Asynchronous reset mid-transfer; pointer is 1 before reset.
        drive(2'b11, 2'b11, 2'b00, 0, 0, 32'h0);
        step();
        #3;
        chk("ar_pre.grant", 32'(grant), 32'h2);
        chk("ar_pre.s_stb", 32'(s_stb), 32'h1);
        step();
        #1;
        rst = 1'b0;
        #1;
        chk("ar_in.s_cyc", 32'(s_cyc), 32'h0);
        chk("ar_in.s_stb", 32'(s_stb), 32'h0);
        chk("ar_in.grant", 32'(grant), 32'h0);
        chk("ar_in.m_err", 32'(m_err), 32'h0);
        step();
        rst = 1'b1;
        #3;
        chk("ar_post.grant", 32'(grant), 32'h0);
        step();
        #3;
        chk("ar_restart.grant", 32'(grant), 32'h1);
        chk("ar_restart.s_adr", s_adr, A0);
        step();
        drive(2'b00, 2'b00, 2'b00, 0, 0, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
